// File: rtl/fifo_ptr_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ptr_pkg
//   Shared definitions for the FIFO gray pointer counter and its receive-side
//   companion: pointer widths, FIFO depth and the 4-bit gray/binary helpers.
//   The same helpers are meant to be reused by the counter and by verification.
// -----------------------------------------------------------------------------
package fifo_ptr_pkg;

    localparam int unsigned PTR_W  = 5;   // binary pointer incl. wrap bit
    localparam int unsigned GRAY_W = 4;   // gray bus carries the low 4 bits only
    localparam int unsigned DEPTH  = 16;

    // MSB-first prefix XOR: bin[i] = bin[i+1] ^ g[i]
    function automatic logic [GRAY_W-1:0] gray2bin4(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [GRAY_W-1:0] bin2gray4(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // True when more than one bit is set, i.e. a gray step that was not legal.
    function automatic logic multi_bit(input logic [GRAY_W-1:0] d);
        logic [2:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < GRAY_W; i++) begin
            cnt = cnt + {2'b00, d[i]};
        end
        return (cnt > 3'd1);
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// -----------------------------------------------------------------------------
// ptr_sync
//   STAGES-deep multi-bit flop chain used to bring an asynchronous gray pointer
//   into the local clock domain. Nothing but flops between stages.
//   Ports:
//     clk_i   - local clock
//     reset_i - synchronous active-high reset, clears every stage to 0
//     d_i     - asynchronous input bus
//     q_o     - synchronized bus (output of the last stage)
// -----------------------------------------------------------------------------
module ptr_sync #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned W      = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_rx.sv
// -----------------------------------------------------------------------------
// gray_ptr_rx
//   Receive side of the FIFO gray pointer: synchronizes the remote 4-bit gray
//   pointer, decodes it, rebuilds the missing wrap bit and compares against the
//   local 5-bit binary pointer to give occupancy, empty and full.
//   Ports:
//     clk          - local clock
//     reset        - synchronous active-high reset
//     gray_in      - remote gray pointer (asynchronous to clk)
//     local_ptr_b  - local binary pointer (synchronous to clk)
//     remote_ptr_b - rebuilt remote binary pointer, registered
//     level        - (remote_ptr_b - local_ptr_b) mod 32
//     empty        - level == 0
//     full         - level == DEPTH
//     gray_err     - sticky: a synchronized sample changed by more than one bit
//   SYNC_STAGES must be 2 or 3; DEPTH_LOG2 is tied to the 4-bit gray bus.
// -----------------------------------------------------------------------------
module gray_ptr_rx
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH_LOG2  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRAY_W-1:0] gray_in,
    input  logic [PTR_W-1:0]  local_ptr_b,
    output logic [PTR_W-1:0]  remote_ptr_b,
    output logic [PTR_W-1:0]  level,
    output logic              empty,
    output logic              full,
    output logic              gray_err
);

    localparam logic [PTR_W-1:0] FULL_LEVEL = PTR_W'(1 << DEPTH_LOG2);

    logic [GRAY_W-1:0] sync_gray;
    logic [GRAY_W-1:0] bin4;
    logic [GRAY_W-1:0] prev_gray;

    logic [GRAY_W-1:0] prev_bin4_q;
    logic              wrap_q,      wrap_d;
    logic [PTR_W-1:0]  remote_q,    remote_d;
    logic              gray_err_q,  gray_err_d;

    ptr_sync #(
        .STAGES (SYNC_STAGES),
        .W      (GRAY_W)
    ) u_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (gray_in),
        .q_o     (sync_gray)
    );

    assign bin4 = gray2bin4(sync_gray);
    // Previous gray sample is re-derived from the stored binary value rather
    // than kept in a second register; the two always agree.
    assign prev_gray = bin2gray4(prev_bin4_q);

    always_comb begin
        // A decrease of the 4-bit value means the remote counter crossed 15->0
        // (remote advances < 16 steps per sample), so the wrap bit flips.
        wrap_d     = wrap_q ^ (bin4 < prev_bin4_q);
        remote_d   = {wrap_d, bin4};
        gray_err_d = gray_err_q | multi_bit(sync_gray ^ prev_gray);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_bin4_q <= '0;
            wrap_q      <= 1'b0;
            remote_q    <= '0;
            gray_err_q  <= 1'b0;
        end else begin
            prev_bin4_q <= bin4;
            wrap_q      <= wrap_d;
            remote_q    <= remote_d;
            gray_err_q  <= gray_err_d;
        end
    end

    // Live local pointer: a local read shows up in empty the same cycle.
    assign level        = remote_q - local_ptr_b;
    assign empty        = (level == '0);
    assign full         = (level == FULL_LEVEL);
    assign remote_ptr_b = remote_q;
    assign gray_err     = gray_err_q;

endmodule

// File: tb/tb_gray_ptr_rx.sv
module tb_gray_ptr_rx;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] gray_in;
    logic [4:0] local_ptr_b;
    logic [4:0] remote_ptr_b;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       gray_err;

    gray_ptr_rx #(
        .SYNC_STAGES (SYNC),
        .DEPTH_LOG2  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .gray_in      (gray_in),
        .local_ptr_b  (local_ptr_b),
        .remote_ptr_b (remote_ptr_b),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .gray_err     (gray_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] remote;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_assert = 0;
    int   n_fail   = 0;

    // reference model state
    logic [3:0] m_prev_b;
    logic [3:0] m_prev_g;
    logic       m_wrap;
    logic       m_err;

    function automatic logic [3:0] ref_decode(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = g[2] ^ b[3];
        b[1] = g[1] ^ b[2];
        b[0] = g[0] ^ b[1];
        return b;
    endfunction

    function automatic logic [3:0] ref_gray(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ {1'b0, b[3:1]};
    endfunction

    function automatic int ones(input logic [3:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string where);
        logic [4:0] lv;
        lv = cur.remote - local_ptr_b;
        chk({where, ":remote"}, remote_ptr_b, cur.remote);
        chk({where, ":level"},  level, lv);
        chk({where, ":empty"},  {4'b0, empty}, {4'b0, lv == 5'd0});
        chk({where, ":full"},   {4'b0, full},  {4'b0, lv == 5'd16});
        chk({where, ":err"},    {4'b0, gray_err}, {4'b0, cur.err});
    endtask

    task automatic push_sample(input logic [3:0] g);
        logic [3:0] b;
        exp_t e;
        b = ref_decode(g);
        if (b < m_prev_b) m_wrap = ~m_wrap;
        if (ones(g ^ m_prev_g) > 1) m_err = 1'b1;
        m_prev_b = b;
        m_prev_g = g;
        e.remote = {m_wrap, b};
        e.err    = m_err;
        sb.push_back(e);
    endtask

    // After reset the synchronizer holds zeros: those samples come out first.
    task automatic reset_model();
        sb.delete();
        m_prev_b = '0;
        m_prev_g = '0;
        m_wrap   = 1'b0;
        m_err    = 1'b0;
        cur      = '0;
        for (int i = 0; i < SYNC; i++) sb.push_back('0);
    endtask

    task automatic tick(input string where);
        if (reset) begin
            @(posedge clk);
            #1;
            reset_model();
            check_outputs({where, "/rst"});
        end else begin
            push_sample(gray_in);
            @(posedge clk);
            #1;
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL %s:sb_underflow observed=%0d expected=%0d", where, sb.size(), 1);
            end
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                check_outputs(where);
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input logic [3:0] g, input logic [4:0] l, input int n, input string where);
        gray_in     = g;
        local_ptr_b = l;
        repeat (n) tick(where);
    endtask

    initial begin
        m_prev_b = '0; m_prev_g = '0; m_wrap = 1'b0; m_err = 1'b0; cur = '0;
        reset       = 1'b1;
        gray_in     = 4'b1101;
        local_ptr_b = 5'd0;

        // reset held with a non-zero gray input, then release: 9 after 3 edges
        step(4'b1101, 5'd0, 2, "reset");
        reset = 1'b0;
        step(4'b1101, 5'd0, 3, "post_reset");

        // clean restart for the single-step test
        reset = 1'b1;
        step(4'b0000, 5'd0, 1, "reset2");
        reset = 1'b0;
        step(4'b0000, 5'd0, 2, "idle");
        step(4'b0001, 5'd0, 3, "single_step");

        // first lap: 2..15 then 0 -> remote 16, level 16, full
        for (int v = 2; v < 16; v++) step(ref_gray(v), 5'd0, 1, "lap1");
        step(4'b0000, 5'd0, 3, "lap1_wrap");

        // local catches up: empty in the same cycle, no clock edge needed
        local_ptr_b = 5'd16;
        #1;
        check_outputs("same_cycle_empty");

        // second lap: 17..31 then 0 -> remote 0, again 16 ahead of local
        for (int v = 1; v < 16; v++) step(ref_gray(v), 5'd16, 1, "lap2");
        step(4'b0000, 5'd16, 3, "lap2_wrap");

        local_ptr_b = 5'd0;
        #1;
        check_outputs("same_cycle_local0");

        // multi-bit jump 3 -> 9: decoded and accepted, sticky error
        step(4'b0010, 5'd0, 3, "pre_jump");
        step(4'b1101, 5'd0, 3, "jump");
        for (int v = 10; v < 16; v++) step(ref_gray(v), 5'd0, 1, "after_jump");
        step(4'b0000, 5'd0, 1, "after_jump");
        for (int v = 1; v < 6; v++) step(ref_gray(v), 5'd0, 1, "to_21");
        step(ref_gray(5), 5'd0, 2, "at_21");

        // reset mid-operation with a new value in flight, then stay at 0
        reset = 1'b1;
        step(4'b0000, 5'd0, 1, "mid_reset");
        reset = 1'b0;
        step(4'b0000, 5'd0, 4, "after_mid_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_ptr_rx.md
# gray_ptr_rx

Receive-side companion to the FIFO gray pointer counter. It takes the 4-bit gray pointer published by the far-side counter and synchronizes it into the local clock domain. It then decodes the pointer to binary and rebuilds the 5th (wrap) bit that the gray bus does not carry. Finally, it compares the rebuilt pointer against the local 5-bit binary pointer to produce FIFO occupancy, empty and full. One instance sits in the read domain and is fed the remote write pointer.

## Interface
Parameters:
- SYNC_STAGES, default 2: number of synchronizer flops on gray_in. Legal values are 2 or 3.
- DEPTH_LOG2, default 4: log2 of the FIFO depth. It is fixed at 4 to match the 4-bit gray bus and 5-bit binary pointer.

Ports:
- clk, input, 1: the only clock (local domain).
- reset, input, 1: synchronous, active-high reset.
- gray_in, input, 4: remote gray pointer, asynchronous to clk. Gray code of remote count[3:0]; at most one bit changes per remote step.
- local_ptr_b, input, 5: local binary pointer, synchronous to clk. Wraps modulo 32.
- remote_ptr_b, output, 5: rebuilt remote binary pointer, registered. Bit 4 is the reconstructed wrap bit.
- level, output, 5: (remote_ptr_b − local_ptr_b) mod 32. Range 0..16.
- empty, output, 1: level == 0.
- full, output, 1: level == 16.
- gray_err, output, 1: sticky flag. Set when two consecutive synchronized gray samples differ in more than one bit.

## Operation
- Synchronizer: gray_in passes through SYNC_STAGES flops, all reset to 0. No logic is allowed between the stages.
- Decode: bin4[3] = g[3]; bin4[i] = bin4[i+1] ^ g[i] for i = 2..0.
- Previous value: a prev_bin4 register holds the last decoded value and resets to 0.
- Wrap rebuild: each cycle, if bin4 < prev_bin4 then wrap_bit toggles; otherwise it holds.
  - wrap_bit resets to 0.
  - remote_ptr_b = {wrap_bit_next, bin4}, registered.
  - Requirement: the remote side advances fewer than 16 steps between consecutive synchronized samples. Faster advance is outside the contract and is not detected.
- Equal samples: no change to any state.
- Level: computed combinationally as a 5-bit modulo subtraction of the registered remote_ptr_b and the live local_ptr_b.
  - A local read is therefore reflected in empty in the same cycle, which makes empty pessimistic-safe.
- Gray error: gray_err is set when popcount(sync_out ^ prev_gray) > 1. It is cleared only by reset.
  - A multi-bit change is still decoded and accepted.
- Reset mid-operation: all synchronizer flops, prev_bin4, wrap_bit, remote_ptr_b and gray_err return to 0 on the next edge.
  - The in-flight gray value is discarded.
  - The local and remote counters must be reset together; this block does not resynchronize the pointers.

## Timing
- Reset values: remote_ptr_b = 0, gray_err = 0. With local_ptr_b = 0, level = 0, empty = 1, full = 0.
- Latency: a gray_in change that is stable before edge N is visible on remote_ptr_b after edge N+SYNC_STAGES. That is 3 edges for the default configuration.
- level, empty and full follow remote_ptr_b with zero additional cycles, and follow local_ptr_b combinationally.
- A simultaneous remote advance and local advance in the same cycle changes level by the net difference. There is no priority between the two.
- full asserts only when the rebuilt remote pointer is exactly 16 ahead of the local pointer.

## Structure
- Shared package fifo_ptr_pkg holds:
  - PTR_W = 5 and GRAY_W = 4.
  - DEPTH = 16.
  - Function gray2bin4 and function bin2gray4.
  - The same functions are reused by the counter and by verification.
- One sub-module: ptr_sync, a SYNC_STAGES-deep multi-bit flop chain with synchronous active-high reset. It is instantiated once for the 4-bit bus.
- The top level holds the decode, wrap rebuild, comparator and error detection.

## Test plan
- Reset: hold reset 2 cycles with gray_in = 1101 → remote_ptr_b = 0, empty = 1, full = 0, gray_err = 0. After release, remote_ptr_b = 9 appears 3 edges later.
- Single step: gray_in goes 0000 → 0001, local_ptr_b = 0 → remote_ptr_b = 1, level = 1, empty = 0, exactly at edge +3.
- Wrap: step the remote pointer through gray 15 (1000) to 0 (0000) → remote_ptr_b goes 15 → 16 (bit 4 set). A second full lap gives 31 → 0.
- Full and empty: local_ptr_b = 0, remote advanced 16 steps → level = 16, full = 1. Then set local_ptr_b = 16 → level = 0, empty = 1 in the same cycle.
- Multi-step jump: gray_in jumps 0010 (3) → 1101 (9) in one sample → remote_ptr_b = 9, gray_err = 1 and it stays set until reset.
- Reset mid-operation: with remote_ptr_b = 21 and gray_err = 1, assert reset for 1 cycle → all state returns to 0 on that edge, and the old gray_in value is not reproduced.
